// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and reset constants.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit with redirect and decoder handshake.
// state  | meaning
// S_REQ  | issue read at pc
// S_WAIT | await mem_ack; drop the response if discard is set
// S_HOLD | present instr until the decoder takes it
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    state_t      state;
    state_t      state_nxt;
    logic        discard;
    logic        discard_nxt;
    logic        accept;
    logic [31:0] pc;

    assign mem_req  = (state == S_REQ);
    assign mem_addr = {pc[31:2], 2'b00};

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        accept      = 1'b0;
        case (state)
            S_REQ: begin
                state_nxt   = S_WAIT;
                discard_nxt = redirect;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    discard_nxt = 1'b0;
                    if (redirect || discard) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_HOLD;
                        accept    = 1'b1;
                    end
                end else if (redirect) begin
                    // the in-flight response belongs to the old path
                    discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || instr_ready) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt   = S_REQ;
                discard_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else if (accept) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            fetch_err   <= (mem_rdata[1:0] != 2'b11);
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
        end else if ((state == S_HOLD) && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/redirect/reset sequence with a memory responder.
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int   errors;
    int   checks;
    exp_t exp_q[$];

    int   mem_delay;
    logic force_dead;
    logic stray;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0000_0000;
            32'h0000_0100: return 32'h00a0_0113;
            default:       return {a[31:2], 2'b11};
        endcase
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // memory responder: acts 2ns after the edge so it sees the stimulus of that cycle
    initial begin : responder
        logic [31:0] a;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_req && resetn) begin
                a = mem_addr;
                repeat (mem_delay) begin
                    @(posedge clk);
                    #2;
                end
                @(posedge clk);
                #2;
                mem_ack   = 1'b1;
                mem_rdata = force_dead ? 32'hDEAD_BEEF : mem_word(a);
            end else if (stray) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h1234_5677;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake_unexpected: got instr=%h pc=%h err=%b, none expected",
                         instr, instr_pc, fetch_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("handshake", {instr, instr_pc, fetch_err}, {e.word, e.pc, e.err});
            end
        end
    end

    initial begin : stim
        int budget;
        errors      = 0;
        checks      = 0;
        resetn      = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_delay   = 0;
        force_dead  = 1'b0;
        stray       = 1'b0;

        tick(3);
        check("reset_state", {instr_valid, fetch_err, instr, instr_pc},
              {1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000});

        resetn = 1'b1;
        exp_q.push_back('{32'h0050_0093, 32'h0, 1'b0});
        check("release_req", {mem_req, mem_addr}, {1'b1, 32'h0});
        tick();
        check("latency_wait", {32'h0, instr_valid}, {32'h0, 1'b0});
        tick();
        check("first_fetch", {instr_valid, instr, instr_pc, fetch_err},
              {1'b1, 32'h0050_0093, 32'h0, 1'b0});

        stray = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stray = 1'b0;
            check("hold_stable", {instr_valid, instr, instr_pc, fetch_err},
                  {1'b1, 32'h0050_0093, 32'h0, 1'b0});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("next_addr_4", {mem_req, mem_addr}, {1'b1, 32'h4});

        tick(2);
        check("fetch_err_set", {instr_valid, instr, instr_pc, fetch_err},
              {1'b1, 32'h0, 32'h4, 1'b1});
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("redirect_hold", {instr_valid, fetch_err, mem_req, mem_addr},
              {1'b0, 1'b0, 1'b1, 32'h0000_0100});
        exp_q.push_back('{32'h00a0_0113, 32'h100, 1'b0});
        instr_ready = 1'b1;

        tick(2);
        check("fetch_100", {instr_valid, instr, instr_pc}, {1'b1, 32'h00a0_0113, 32'h100});
        mem_delay = 1;
        tick();
        check("req_104", {mem_req, mem_addr}, {1'b1, 32'h104});
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        force_dead  = 1'b1;
        tick();
        redirect  = 1'b0;
        mem_delay = 0;
        check("wait_discard", {mem_req, instr_valid}, {1'b0, 1'b0});
        tick();
        force_dead = 1'b0;
        check("after_drop", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, 32'h100});
        exp_q.push_back('{32'h00a0_0113, 32'h100, 1'b0});
        exp_q.push_back('{32'h0000_0107, 32'h104, 1'b0});

        tick(6);
        check("throughput_108", {mem_req, mem_addr}, {1'b1, 32'h108});
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("redirect_in_req", {mem_req, instr_valid}, {1'b0, 1'b0});
        tick();
        check("req_top", {mem_req, mem_addr}, {1'b1, 32'hFFFF_FFFC});
        exp_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0});
        tick(3);
        check("pc_wrap", {mem_req, mem_addr}, {1'b1, 32'h0});
        exp_q.push_back('{32'h0050_0093, 32'h0, 1'b0});

        tick(2);
        check("valid_before_coincide", {32'h0, instr_valid}, {32'h0, 1'b1});
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check("coincide_redirect", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, 32'h200});

        tick(2);
        check("fetch_200", {instr_valid, instr, instr_pc}, {1'b1, 32'h0000_0203, 32'h200});
        resetn = 1'b0;
        tick();
        check("reset_in_hold", {instr_valid, fetch_err, instr, instr_pc},
              {1'b0, 1'b0, 32'h0000_0013, 32'h0});
        resetn = 1'b1;
        check("reset_req", {mem_req, mem_addr}, {1'b1, 32'h0});
        exp_q.push_back('{32'h0050_0093, 32'h0, 1'b0});
        instr_ready = 1'b1;

        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("scoreboard_drained", {33'h0, 32'(exp_q.size())}, 65'h0);
        instr_ready = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
